// File: rtl/sync_trigger_gen.sv
// Multi-channel trigger unit: synchronised edge detect, prescaler and delayed width-programmed pulse.
// Define SYNC_TRIG_SYNC_EN to add a two-flop metastability synchroniser on every SYNC_IN.
module sync_trigger_gen #(
    parameter int CHANNELS       = 2,
    parameter int DELAY_WIDTH    = 16,
    parameter int WIDTH_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [CHANNELS-1:0]                SYNC_IN,
    input  logic [CHANNELS-1:0]                ENABLE,
    input  logic [CHANNELS-1:0]                EDGE_SEL,
    input  logic [CHANNELS*DELAY_WIDTH-1:0]    DELAY,
    input  logic [CHANNELS*WIDTH_WIDTH-1:0]    WIDTH,
    input  logic [CHANNELS*PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [CHANNELS-1:0]                STROBE,
    output logic [CHANNELS-1:0]                PULSE,
    output logic [CHANNELS-1:0]                BUSY,
    output logic [CHANNELS*16-1:0]             TRIG_CNT,
    output logic [CHANNELS*8-1:0]              MISSED_CNT
);
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_PULSE} state_t;

    logic [CHANNELS-1:0] samp_q;
    logic [CHANNELS-1:0] hist_q;
    logic [CHANNELS-1:0] edge_det;
    logic [1:0]          arm_q;
    logic                armed;

`ifdef SYNC_TRIG_SYNC_EN
    localparam logic [1:0] ARM_CYCLES = 2'd3;
    logic [CHANNELS-1:0] meta_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= '0;
            samp_q <= '0;
        end else begin
            meta_q <= SYNC_IN;
            samp_q <= meta_q;
        end
    end
`else
    localparam logic [1:0] ARM_CYCLES = 2'd2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_q <= '0;
        end else begin
            samp_q <= SYNC_IN;
        end
    end
`endif

    // Edges are ignored until the history flop compares two post-reset samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= '0;
            arm_q  <= '0;
        end else begin
            hist_q <= samp_q;
            if (arm_q != ARM_CYCLES) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    assign armed    = (arm_q == ARM_CYCLES);
    assign edge_det = (EDGE_SEL & hist_q & ~samp_q) | (~EDGE_SEL & samp_q & ~hist_q);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DELAY_WIDTH-1:0]    cfg_dly;
        logic [WIDTH_WIDTH-1:0]    cfg_wid;
        logic [PRESCALE_WIDTH-1:0] cfg_presc;
        state_t                    state_q, state_d;
        logic [DELAY_WIDTH-1:0]    dly_q, dly_d;
        logic [WIDTH_WIDTH-1:0]    wid_q, wid_d;
        logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
        logic [15:0]               trig_q, trig_d;
        logic [7:0]                miss_q, miss_d;
        logic                      strobe_q, strobe_d;
        logic                      hit;

        assign cfg_dly   = DELAY[c*DELAY_WIDTH +: DELAY_WIDTH];
        assign cfg_wid   = WIDTH[c*WIDTH_WIDTH +: WIDTH_WIDTH];
        assign cfg_presc = PRESCALE[c*PRESCALE_WIDTH +: PRESCALE_WIDTH];

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q  <= ST_IDLE;
                dly_q    <= '0;
                wid_q    <= '0;
                presc_q  <= '0;
                trig_q   <= '0;
                miss_q   <= '0;
                strobe_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                dly_q    <= dly_d;
                wid_q    <= wid_d;
                presc_q  <= presc_d;
                trig_q   <= trig_d;
                miss_q   <= miss_d;
                strobe_q <= strobe_d;
            end
        end

        always_comb begin
            strobe_d = ENABLE[c] & armed & edge_det[c];
            hit      = 1'b0;
            presc_d  = presc_q;
            state_d  = state_q;
            dly_d    = dly_q;
            wid_d    = wid_q;
            trig_d   = trig_q;
            miss_d   = miss_q;

            if (!ENABLE[c]) begin
                presc_d = '0;
            end else if (strobe_q) begin
                if (presc_q >= cfg_presc) begin
                    hit     = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PRESCALE_WIDTH'(1);
                end
            end

            if (hit && state_q != ST_IDLE && miss_q != 8'hFF) begin
                miss_d = miss_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        trig_d = trig_q + 16'd1;
                        dly_d  = cfg_dly;
                        wid_d  = cfg_wid;
                        // A zero width counts the trigger but never leaves IDLE.
                        if (cfg_wid != '0) begin
                            state_d = (cfg_dly != '0) ? ST_DELAY : ST_PULSE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_q <= DELAY_WIDTH'(1)) begin
                        state_d = ST_PULSE;
                    end else begin
                        dly_d = dly_q - DELAY_WIDTH'(1);
                    end
                end
                ST_PULSE: begin
                    if (wid_q <= WIDTH_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        wid_d = wid_q - WIDTH_WIDTH'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (!ENABLE[c]) begin
                state_d = ST_IDLE;
            end
        end

        assign STROBE[c]             = strobe_q;
        assign PULSE[c]              = (state_q == ST_PULSE);
        assign BUSY[c]               = (state_q != ST_IDLE);
        assign TRIG_CNT[c*16 +: 16]  = trig_q;
        assign MISSED_CNT[c*8 +: 8]  = miss_q;
    end
endmodule

// File: tb/tb_sync_trigger_gen.sv
// Directed bench for sync_trigger_gen: table of per-channel trigger scenarios plus reset,
// arming, saturation, enable-drop and simultaneous-channel sequences.
module tb_sync_trigger_gen;
    localparam int CH = 2;
`ifdef SYNC_TRIG_SYNC_EN
    localparam int SLAT = 3;
`else
    localparam int SLAT = 2;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic [CH-1:0]       SYNC_IN, ENABLE, EDGE_SEL;
    logic [CH*16-1:0]    DELAY;
    logic [CH*8-1:0]     WIDTH, PRESCALE;
    logic [CH-1:0]       STROBE, PULSE, BUSY;
    logic [CH*16-1:0]    TRIG_CNT;
    logic [CH*8-1:0]     MISSED_CNT;

    int checks = 0;
    int errors = 0;

    sync_trigger_gen #(
        .CHANNELS(CH), .DELAY_WIDTH(16), .WIDTH_WIDTH(8), .PRESCALE_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .SYNC_IN(SYNC_IN), .ENABLE(ENABLE), .EDGE_SEL(EDGE_SEL),
        .DELAY(DELAY), .WIDTH(WIDTH), .PRESCALE(PRESCALE),
        .STROBE(STROBE), .PULSE(PULSE), .BUSY(BUSY),
        .TRIG_CNT(TRIG_CNT), .MISSED_CNT(MISSED_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch; bit esel; int dly; int wid; int presc; int nedges; int gap;
        int exp_strobes; int exp_pulses; int exp_hi; int exp_busy;
        int exp_trig; int exp_miss; int exp_off;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic configure(input int ch, input bit esel, input int dly, input int wid, input int presc);
        ENABLE[ch]              = 1'b0;
        EDGE_SEL[ch]            = esel;
        SYNC_IN[ch]             = esel;
        DELAY[ch*16 +: 16]      = 16'(dly);
        WIDTH[ch*8 +: 8]        = 8'(wid);
        PRESCALE[ch*8 +: 8]     = 8'(presc);
        repeat (4) step();
        ENABLE[ch] = 1'b1;
        step();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int strobes = 0, rises = 0, hi = 0, busy = 0, first = -1;
        int trig0, miss0, total, exp_first;
        logic prev = 1'b0;
        configure(v.ch, v.esel, v.dly, v.wid, v.presc);
        trig0 = int'(TRIG_CNT[v.ch*16 +: 16]);
        miss0 = int'(MISSED_CNT[v.ch*8 +: 8]);
        total = v.nedges * v.gap + v.dly + v.wid + 20;
        for (int t = 0; t < total; t++) begin
            SYNC_IN[v.ch] = (t < v.nedges * v.gap && (t % v.gap) < 2) ? ~v.esel : v.esel;
            step();
            strobes += int'(STROBE[v.ch]);
            if (PULSE[v.ch] && !prev) begin
                rises++;
                if (first < 0) first = t + 1;
            end
            prev  = PULSE[v.ch];
            hi   += int'(PULSE[v.ch]);
            busy += int'(BUSY[v.ch]);
        end
        exp_first = (v.exp_off < 0) ? -1 : v.exp_off + SLAT;
        chk($sformatf("v%0d_strobes", idx), strobes, v.exp_strobes);
        chk($sformatf("v%0d_pulses", idx), rises, v.exp_pulses);
        chk($sformatf("v%0d_pulse_cycles", idx), hi, v.exp_hi);
        chk($sformatf("v%0d_busy_cycles", idx), busy, v.exp_busy);
        chk($sformatf("v%0d_first_pulse", idx), first, exp_first);
        chk($sformatf("v%0d_trig_delta", idx), (int'(TRIG_CNT[v.ch*16 +: 16]) - trig0) & 32'hFFFF, v.exp_trig);
        chk($sformatf("v%0d_miss_delta", idx), int'(MISSED_CNT[v.ch*8 +: 8]) - miss0, v.exp_miss);
    endtask

    initial begin
        int cnt, t0, t1, r0, r1, s0, s1, tr0, tr1, trs;
        bit seen;

        //        ch esel dly wid psc n gap  str pul hi busy trig miss off
        vecs[0] = '{0, 1,  3,  3, 0, 1, 8,   1,  1,  3,  6,  1,  0,  4};
        vecs[1] = '{0, 0,  0,  5, 0, 1, 8,   1,  1,  5,  5,  1,  0,  1};
        vecs[2] = '{1, 0,  0,  2, 2, 7, 6,   7,  2,  4,  4,  2,  0, 13};
        vecs[3] = '{0, 0, 10,  4, 0, 2, 6,   2,  1,  4, 14,  1,  1, 11};
        vecs[4] = '{0, 0,  2,  0, 0, 1, 8,   1,  0,  0,  0,  1,  0, -1};
        vecs[5] = '{1, 0,  0,  4, 0, 2, 5,   2,  2,  8,  8,  2,  0,  1};
        vecs[6] = '{1, 0,  0,  4, 0, 2, 4,   2,  1,  4,  4,  1,  1,  1};
        vecs[7] = '{0, 1,  1,  1, 1, 3, 4,   3,  1,  1,  2,  1,  0,  6};

        // Both inputs static high through reset; ch1 selects rising edge to exercise arming.
        RST = 1'b1; SYNC_IN = 2'b11; EDGE_SEL = 2'b01; ENABLE = 2'b11;
        DELAY = '0; WIDTH = {8'd1, 8'd1}; PRESCALE = '0;
        repeat (3) step();
        chk("rst_strobe", 32'(STROBE), 0);
        chk("rst_pulse", 32'(PULSE), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_trig", 32'(TRIG_CNT), 0);
        chk("rst_miss", 32'(MISSED_CNT), 0);
        RST = 1'b0;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            cnt += int'(STROBE[0]) + int'(STROBE[1]) + int'(BUSY[0]) + int'(BUSY[1]);
        end
        chk("arm_no_strobe", cnt, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Simultaneous edges on both channels with distinct delays.
        ENABLE = 2'b00; EDGE_SEL = 2'b00; SYNC_IN = 2'b00;
        DELAY = {16'd7, 16'd3}; WIDTH = {8'd3, 8'd2}; PRESCALE = '0;
        repeat (4) step();
        ENABLE = 2'b11;
        step();
        tr0 = int'(TRIG_CNT[15:0]); tr1 = int'(TRIG_CNT[31:16]);
        r0 = -1; r1 = -1; s0 = -1; s1 = -1;
        for (int t = 0; t < 30; t++) begin
            SYNC_IN = (t < 2) ? 2'b11 : 2'b00;
            step();
            if (STROBE[0] && s0 < 0) s0 = t + 1;
            if (STROBE[1] && s1 < 0) s1 = t + 1;
            if (PULSE[0] && r0 < 0) r0 = t + 1;
            if (PULSE[1] && r1 < 0) r1 = t + 1;
        end
        chk("sim_strobe_ch0", s0, SLAT);
        chk("sim_strobe_ch1", s1, SLAT);
        chk("sim_pulse_ch0", r0, SLAT + 4);
        chk("sim_pulse_ch1", r1, SLAT + 8);
        chk("sim_trig_ch0", int'(TRIG_CNT[15:0]) - tr0, 1);
        chk("sim_trig_ch1", int'(TRIG_CNT[31:16]) - tr1, 1);

        // 300 edges against a very long delay: one accepted, the rest saturate MISSED_CNT.
        configure(0, 1'b0, 5000, 4, 0);
        trs = int'(TRIG_CNT[15:0]);
        cnt = 0;
        for (int t = 0; t < 1200; t++) begin
            SYNC_IN[0] = ((t % 4) < 2);
            step();
            cnt += int'(STROBE[0]);
        end
        SYNC_IN[0] = 1'b0;
        step();
        chk("sat_strobes", cnt, 300);
        chk("sat_miss", 32'(MISSED_CNT[7:0]), 255);
        chk("sat_trig_delta", int'(TRIG_CNT[15:0]) - trs, 1);
        chk("sat_busy_in_delay", 32'(BUSY[0]), 1);
        ENABLE[0] = 1'b0;
        step();
        chk("en_drop_pulse", 32'(PULSE[0]), 0);
        chk("en_drop_busy", 32'(BUSY[0]), 0);
        chk("en_drop_trig_hold", int'(TRIG_CNT[15:0]) - trs, 1);
        chk("en_drop_miss_hold", 32'(MISSED_CNT[7:0]), 255);

        // Asynchronous reset in the middle of a pulse.
        configure(0, 1'b0, 0, 20, 0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            SYNC_IN[0] = (t < 2);
            step();
            if (PULSE[0]) seen = 1'b1;
        end
        chk("rst_mid_pulse_seen", 32'(seen), 1);
        step();
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_pulse", 32'(PULSE), 0);
        chk("async_rst_busy", 32'(BUSY), 0);
        chk("async_rst_strobe", 32'(STROBE), 0);
        chk("async_rst_trig", 32'(TRIG_CNT), 0);
        chk("async_rst_miss", 32'(MISSED_CNT), 0);
        SYNC_IN[0] = 1'b0;
        step();
        RST = 1'b0;
        repeat (6) step();
        chk("post_rst_busy", 32'(BUSY), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_trigger_gen.md
# sync_trigger_gen

Parametrised multi-channel trigger unit for the probe-card top level. It replaces the hand-written row2sync/frame-sync edge detectors feeding the pulse generators. Each channel synchronises an external sync input and detects a selectable edge. It applies a prescaler, then produces a one-cycle strobe and a delayed, width-programmed pulse that starts the sequence generator and sequence recorders. Per-channel accepted and missed trigger counts are kept for readout through GPIO.

## Interface
Parameters:
- CHANNELS, 2, number of independent trigger channels (1..8)
- DELAY_WIDTH, 16, bits of per-channel delay value
- WIDTH_WIDTH, 8, bits of per-channel pulse width value
- PRESCALE_WIDTH, 8, bits of per-channel prescale value

Ports (per-channel vectors are packed with channel 0 in the LSBs):
- CLK  in  1  single clock for all logic (CLK_320 or CLK_80 domain)
- RST  in  1  reset, asynchronous and active-high
- SYNC_IN  in  CHANNELS  external sync inputs, asynchronous to CLK
- ENABLE  in  CHANNELS  channel enable, quasi-static
- EDGE_SEL  in  CHANNELS  0 = rising edge, 1 = falling edge
- DELAY  in  CHANNELS*DELAY_WIDTH  cycles from accepted strobe to pulse start
- WIDTH  in  CHANNELS*WIDTH_WIDTH  pulse length in cycles
- PRESCALE  in  CHANNELS*PRESCALE_WIDTH  accept one of every PRESCALE+1 strobes
- STROBE  out  CHANNELS  one-cycle detected-edge strobe, registered
- PULSE  out  CHANNELS  delayed trigger pulse, registered
- BUSY  out  CHANNELS  channel in DELAY or PULSE state
- TRIG_CNT  out  CHANNELS*16  accepted triggers, wraps 0xFFFF->0
- MISSED_CNT  out  CHANNELS*8  dropped triggers, saturates at 0xFF

## Operation
- Input path: SYNC_IN passes through the synchroniser (see Configuration), then one history flop. An edge matching EDGE_SEL with ENABLE=1 sets STROBE for exactly one cycle.
- Arming: after RST deasserts, STROBE is suppressed until the history flops hold valid samples. This takes 3 cycles with SYNC_TRIG_SYNC_EN and 2 cycles without. An input that is static-high at reset release produces no strobe.
- Prescaler: counts strobes 0..PRESCALE. A strobe with count==PRESCALE is a hit, and the count returns to 0. PRESCALE=0 means every strobe is a hit.
- Per-channel FSM, IDLE -> DELAY -> PULSE -> IDLE:
  - IDLE: on a hit, latch DELAY and WIDTH and increment TRIG_CNT. Go to DELAY if DELAY>0, else to PULSE. If WIDTH=0, the hit is counted but the channel stays in IDLE and no pulse is produced.
  - DELAY: decrement the latched delay. Go to PULSE when it reaches 1.
  - PULSE: PULSE=1. Decrement the latched width. Go to IDLE after WIDTH cycles.
- A hit while in DELAY or PULSE is dropped: MISSED_CNT increments (saturating), TRIG_CNT is unchanged, and the current pulse is unaffected.
- Changing DELAY, WIDTH or PRESCALE mid-operation affects only later hits. The latched copies govern the current pulse.
- ENABLE falling:
  - the FSM goes to IDLE;
  - PULSE, BUSY and STROBE go to 0 on the next edge;
  - the prescale count clears;
  - the counters hold.
- Channels are fully independent. Simultaneous edges on several channels are all processed in the same cycle.
- RST at any time: every output goes to 0 immediately (STROBE, PULSE, BUSY, TRIG_CNT, MISSED_CNT). The FSMs go to IDLE, the prescalers clear, and arming restarts.

## Timing
- Edge-to-STROBE latency: SYNC_IN transition first sampled at edge k gives STROBE high during the cycle after edge k+2 with the macro, k+1 without.
- STROBE-to-PULSE: PULSE rises DELAY+1 edges after the edge that asserts STROBE. DELAY=0 gives PULSE in the cycle directly after STROBE.
- PULSE stays high for exactly WIDTH cycles. BUSY covers the DELAY and PULSE states and falls together with PULSE.
- The earliest re-acceptance is a hit in the cycle after PULSE falls. A hit in the last PULSE cycle is missed.
- TRIG_CNT and MISSED_CNT update on the edge following the STROBE cycle.
- Minimum SYNC_IN pulse: 2 CLK periods high or low for guaranteed detection.

## Configuration
- SYNC_TRIG_SYNC_EN defined: two-flop metastability synchroniser per SYNC_IN, plus the history flop (3-cycle input latency).
- Not defined: single input register plus the history flop (2-cycle latency). Use only when SYNC_IN is already in the CLK domain (e.g. from an ISERDES output).

## Test plan
- Rising edge on ch0, DELAY=0, WIDTH=5, PRESCALE=0, macro defined -> STROBE at k+3; PULSE high 5 cycles starting k+4; TRIG_CNT=1.
- PRESCALE=2, 7 edges on ch1 -> 7 strobes, hits on strobes 3 and 6, 2 pulses, TRIG_CNT=2.
- DELAY=10, WIDTH=4, second edge 6 cycles after the first -> one pulse, MISSED_CNT=1; 300 rapid edges -> MISSED_CNT saturates at 0xFF.
- EDGE_SEL=1 with SYNC_IN held high through reset release -> no STROBE; a falling edge then produces STROBE and PULSE.
- RST asserted mid-PULSE, and separately ENABLE dropped mid-DELAY -> PULSE=0 and BUSY=0; counters zeroed only by RST.
- Edges on all CHANNELS in the same cycle with distinct DELAY values -> independent pulses at the correct offsets, each TRIG_CNT=1.
